sync_fifo_param: RTL

Single-clock, parametrised FIFO. It is the next-generation buffer for same-domain paths in the FIFO family and keeps that family's signal set: wt_en/wdata/rd_en/rdata/full/empty/overflow/underflow. It adds configurable depth, programmable almost-full and almost-empty thresholds, and an occupancy count. An optional first-word-fall-through read mode is selected at compile time.

---
 rtl/sync_fifo_param.sv | 120 ++++++++++++
 1 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with almost-full/almost-empty thresholds and an occupancy count.
// Define SYNC_FIFO_FWFT_EN at compile time for first-word-fall-through reads (head held in rdata).
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wt_en,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic                    overflow,
    output logic                    underflow,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  mem_we;

    // All flags are decoded from registered state; requests never reach them combinationally.
    assign full         = (count == FULL_CNT);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);
    assign wr_acc       = wt_en && !full;
    assign rd_acc       = rd_en && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wt_en && full;
            underflow <= rd_en && empty;
            if (wr_acc && !rd_acc)
                count <= count + CW'(1);
            else if (rd_acc && !wr_acc)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[wr_ptr] <= wdata;
    end

`ifdef SYNC_FIFO_FWFT_EN
    logic          out_valid;
    logic [CW-1:0] mem_cnt;
    logic          load_out;
    logic          bypass;

    // count includes the output register, so the array holds count minus the head.
    assign empty    = !out_valid;
    assign mem_cnt  = count - {{(CW-1){1'b0}}, out_valid};
    assign load_out = !out_valid || rd_acc;
    assign bypass   = load_out && (mem_cnt == '0) && wr_acc;
    assign mem_we   = wr_acc && !bypass;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rdata     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (mem_we)
                wr_ptr <= wr_ptr + AW'(1);
            if (load_out) begin
                if (mem_cnt != '0) begin
                    rdata     <= mem[rd_ptr];
                    rd_ptr    <= rd_ptr + AW'(1);
                    out_valid <= 1'b1;
                end else if (wr_acc) begin
                    rdata     <= wdata;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end
`else
    assign empty  = (count == '0);
    assign mem_we = wr_acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rdata  <= '0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc) begin
                rdata  <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end
`endif

endmodule
